ysyx_220066_ifu: RTL

YSYX_220066_IFU -- requirements
Module: ysyx_220066_IFU

---
 rtl/ysyx_220066_ifu_pkg.sv | 28 ++
 rtl/ysyx_220066_ifu_fifo.sv | 66 ++++++
 rtl/ysyx_220066_ifu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_ifu_pkg.sv
// Shared fetch-stage definitions: datapath width, reset PC, NOP encoding, buffer entry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ysyx_220066_defs;

    localparam int              XLEN             = 64;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

    // One instruction-buffer entry as seen by decode.
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    // Faulting fetches carry a NOP so decode never sees garbage bits.
    function automatic fetch_entry_t make_entry(input logic [31:0]     data,
                                                input logic [XLEN-1:0] pc,
                                                input logic            err);
        fetch_entry_t e;
        e.instr = err ? NOP_INSTR : data;
        e.pc    = pc;
        e.fault = err;
        return e;
    endfunction

endpackage

// File: rtl/ysyx_220066_ifu_fifo.sv
// Instruction buffer between fetch and decode, DEPTH entries of {instr, pc, fault}.
// Latency: a push is visible on out_vld/out_dat the cycle after it is written.
// Backpressure: caller never pushes into a full buffer (credit-managed); flush empties it at once.
module ysyx_220066_IFU_FIFO
    import ysyx_220066_defs::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push_vld,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output logic         out_vld,
    output fetch_entry_t out_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign do_pop  = pop && out_vld;
    assign do_push = push_vld && ((count != CW'(DEPTH)) || do_pop);

    // Storage, pointers and occupancy; flush drops every entry but leaves storage contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_220066_ifu.sv
// Instruction fetch: issues PC-sequential requests, tags responses in order, buffers them for decode.
// Latency: response to out_valid is 1 cycle; first request the cycle after reset release.
// Backpressure: requests only while buffered + in-flight < DEPTH; redirect flushes and drops in-flight.
module ysyx_220066_ifu
    import ysyx_220066_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] tag_q [DEPTH];
    logic [AW-1:0]   tag_wr;
    logic [AW-1:0]   tag_rd;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            misalign_stall;
    logic            fault_pending;

    logic            req_fire;
    logic            resp_drop;
    logic            resp_keep;
    logic            fault_push;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_vld;
    fetch_entry_t    buf_push_dat;
    fetch_entry_t    buf_out_dat;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outstanding requests (including ones that will be dropped) hold a buffer credit.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !halt && !redirect_valid && !misalign_stall
                          && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle, or while stale ones remain, belongs to the old path.
    assign resp_drop  = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
    assign resp_keep  = imem_resp_valid && !resp_drop;
    // The misaligned-target fault is queued only once every stale response has drained.
    assign fault_push = fault_pending && (drop_cnt == '0) && !redirect_valid;

    assign buf_push     = resp_keep || fault_push;
    assign buf_push_dat = fault_push ? make_entry(NOP_INSTR, fetch_pc, 1'b1)
                                     : make_entry(imem_resp_data, tag_q[tag_rd], imem_resp_err);
    // Redirect wins over a concurrent decode handshake; the popped entry is flushed anyway.
    assign buf_pop      = buf_vld && out_ready && !redirect_valid;

    assign out_valid = buf_vld;
    assign out_instr = buf_out_dat.instr;
    assign out_pc    = buf_out_dat.pc;
    assign out_fault = buf_out_dat.fault;

    // Fetch PC and misaligned-redirect state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            misalign_stall <= 1'b0;
            fault_pending  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc;
            misalign_stall <= |redirect_pc[1:0];
            fault_pending  <= |redirect_pc[1:0];
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (fault_push) begin
                fault_pending <= 1'b0;
            end
        end
    end

    // Tag storage: the address of each accepted request, read back by its in-order response.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end

    // Tag queue pointers and in-flight count; every response retires one tag, kept or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
        end else begin
            if (req_fire) begin
                tag_wr <= ptr_inc(tag_wr);
            end
            if (imem_resp_valid) begin
                tag_rd <= ptr_inc(tag_rd);
            end
            case ({req_fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Number of in-flight responses still belonging to the pre-redirect path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CW'(imem_resp_valid);
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    ysyx_220066_IFU_FIFO #(
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (buf_push),
        .push_dat (buf_push_dat),
        .pop      (buf_pop),
        .out_vld  (buf_vld),
        .out_dat  (buf_out_dat),
        .count    (fifo_count)
    );

endmodule
